// File: rtl/aes_pkg.sv
// Constants and types shared by the AES S-box datapath blocks.
package aes_pkg;

    localparam int STATE_W   = 128;
    localparam int WORD_W    = 32;
    localparam int BYTE_W    = 8;
    localparam int NUM_LANES = 4;
    localparam int NUM_BEATS = STATE_W / WORD_W;

    localparam logic REQ_ST = 1'b0;
    localparam logic REQ_KW = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST_RUN = 2'd1,
        KW_RUN = 2'd2
    } state_e;

endpackage

// File: rtl/sbox.sv
// AES forward S-box, one byte, purely combinational table lookup.
module sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry 0 sits in the most significant byte of the first row.
    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX_TBL[in_byte];

endmodule

// File: rtl/sbox_lanes4.sv
// One 32-bit word through four parallel S-box lanes.
module sbox_lanes4
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] lane_in,
    output logic [WORD_W-1:0] lane_out
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        sbox u_sbox (
            .in_byte  (lane_in[i*BYTE_W +: BYTE_W]),
            .out_byte (lane_out[i*BYTE_W +: BYTE_W])
        );
    end

endmodule

// File: rtl/sbox_share_arbiter.sv
// Round-robin sharing of four S-box lanes between SubBytes and SubWord.
module sbox_share_arbiter
    import aes_pkg::*;
#(
    parameter logic RR_INIT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               st_req_valid,
    input  logic [STATE_W-1:0] st_req_data,
    output logic               st_req_ready,
    output logic               st_rsp_valid,
    output logic [STATE_W-1:0] st_rsp_data,
    input  logic               kw_req_valid,
    input  logic [WORD_W-1:0]  kw_req_data,
    output logic               kw_req_ready,
    output logic               kw_rsp_valid,
    output logic [WORD_W-1:0]  kw_rsp_data,
    output logic               busy
);

    localparam int BEAT_W = $clog2(NUM_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    state_e             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               rr_q, rr_d;
    logic [STATE_W-1:0] buf_q, buf_d;
    logic [STATE_W-1:0] st_rsp_data_q, st_rsp_data_d;
    logic [WORD_W-1:0]  kw_rsp_data_q, kw_rsp_data_d;
    logic               st_rsp_valid_q, st_rsp_valid_d;
    logic               kw_rsp_valid_q, kw_rsp_valid_d;

    logic [WORD_W-1:0]  lane_in;
    logic [WORD_W-1:0]  lane_out;
    logic               idle;
    logic               grant_st;
    logic               grant_kw;
    logic               st_acc;
    logic               kw_acc;

    // Readies are withheld during reset so nothing is accepted then.
    assign idle     = (state_q == IDLE) && !rst;
    assign grant_st = st_req_valid && (!kw_req_valid || rr_q == REQ_ST);
    assign grant_kw = kw_req_valid && (!st_req_valid || rr_q == REQ_KW);

    assign st_req_ready = idle && grant_st;
    assign kw_req_ready = idle && grant_kw;
    assign st_acc       = st_req_valid && st_req_ready;
    assign kw_acc       = kw_req_valid && kw_req_ready;

    assign lane_in = buf_q[WORD_W*int'(beat_q) +: WORD_W];

    sbox_lanes4 u_lanes (
        .lane_in  (lane_in),
        .lane_out (lane_out)
    );

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        rr_d           = rr_q;
        buf_d          = buf_q;
        st_rsp_data_d  = st_rsp_data_q;
        kw_rsp_data_d  = kw_rsp_data_q;
        st_rsp_valid_d = 1'b0;
        kw_rsp_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                beat_d = '0;
                if (st_acc) begin
                    buf_d   = st_req_data;
                    rr_d    = REQ_KW;
                    state_d = ST_RUN;
                end else if (kw_acc) begin
                    buf_d   = STATE_W'(kw_req_data);
                    rr_d    = REQ_ST;
                    state_d = KW_RUN;
                end
            end
            ST_RUN: begin
                st_rsp_data_d[WORD_W*int'(beat_q) +: WORD_W] = lane_out;
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) begin
                    state_d        = IDLE;
                    st_rsp_valid_d = 1'b1;
                end
            end
            KW_RUN: begin
                kw_rsp_data_d  = lane_out;
                kw_rsp_valid_d = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            rr_q           <= RR_INIT;
            buf_q          <= '0;
            st_rsp_data_q  <= '0;
            kw_rsp_data_q  <= '0;
            st_rsp_valid_q <= 1'b0;
            kw_rsp_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            rr_q           <= rr_d;
            buf_q          <= buf_d;
            st_rsp_data_q  <= st_rsp_data_d;
            kw_rsp_data_q  <= kw_rsp_data_d;
            st_rsp_valid_q <= st_rsp_valid_d;
            kw_rsp_valid_q <= kw_rsp_valid_d;
        end
    end

    assign st_rsp_valid = st_rsp_valid_q;
    assign st_rsp_data  = st_rsp_data_q;
    assign kw_rsp_valid = kw_rsp_valid_q;
    assign kw_rsp_data  = kw_rsp_data_q;
    assign busy         = (state_q != IDLE);

endmodule
